// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SD command-line engine.
// Optional receive CRC checking is enabled by SDCARD_CMD_CRC_CHECK_EN.
package sdcard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_TURN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_R48  = 2'b01,
    RESP_R136 = 2'b10,
    RESP_R3   = 2'b11
  } resp_t;

  localparam int ERR_TMO = 0;
  localparam int ERR_CRC = 1;
  localparam int ERR_END = 2;
  localparam int ERR_IDX = 3;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int FRAME48  = 48;
  localparam int FRAME136 = 136;
  localparam int CRC_BITS = 40;

endpackage

// File: rtl/sdcard_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
// Shared by the command transmitter and the response checker.
module sdcard_crc7
  import sdcard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sdcard_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command, captures R48/R136 replies.
// Define SDCARD_CMD_CRC_CHECK_EN to check the response CRC7.
module sdcard_cmd_engine
  import sdcard_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CYCLES   = 8
) (
  input  logic         PCLK_i,
  input  logic         PRESETn_i,
  input  logic         sd_clk_en_i,
  input  logic         cmd_start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  input  logic         cmd_abort_i,
  input  logic         cmd_in_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic         cmd_ready_o,
  output logic         cmd_busy_o,
  output logic         done_o,
  output logic [127:0] resp_o,
  output logic [3:0]   err_o
);

  localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);

  state_t             state_q, state_d;
  resp_t              rtype_q;
  logic [5:0]         idx_q;
  logic [39:0]        tx_sh;
  logic [127:0]       rx_sh;
  logic [7:0]         cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [3:0]         err_q;
  logic [127:0]       resp_q;
  logic               out_q;
  logic               oe_q;

  logic               abort;
  logic               strobe;
  logic               is136;
  logic               last_rx;
  logic               tmo_hit;
  logic               start_bit;
  logic               tx_crc_en;
  logic [6:0]         tx_crc;
  logic [2:0]         crc_sel;
  logic               tx_bit;
  logic               idx_bad;
  logic               end_bad;
  logic               crc_bad;

  // Abort wins over a coincident bit strobe.
  assign abort     = cmd_abort_i && (state_q != ST_IDLE);
  assign strobe    = sd_clk_en_i && !abort;
  assign is136     = rtype_q == RESP_R136;
  assign start_bit = !cmd_in_i;
  assign tmo_hit   = tmo_q == TMO_W'(RESP_TIMEOUT - 1);
  assign last_rx   = cnt_q == (is136 ? 8'(FRAME136 - 1)
                                     : 8'(FRAME48 - 1));

  assign tx_crc_en = strobe && (state_q == ST_TX)
                  && (cnt_q < 8'(CRC_BITS));
  assign crc_sel   = 3'(8'd46 - cnt_q);

  sdcard_crc7 u_tx_crc (
    .clk    (PCLK_i),
    .rst_n  (PRESETn_i),
    .clear  (state_q == ST_IDLE),
    .enable (tx_crc_en),
    .bit_in (tx_sh[39]),
    .crc    (tx_crc)
  );

  always_comb begin
    tx_bit = 1'b1;
    unique case (1'b1)
      (cnt_q < 8'd40):
        tx_bit = tx_sh[39];
      (cnt_q >= 8'd40 && cnt_q < 8'd47):
        tx_bit = tx_crc[crc_sel];
      default:
        tx_bit = 1'b1;
    endcase
  end

  // rx_sh has not yet taken the final (end) bit when checks run.
  assign idx_bad = (rtype_q == RESP_R48)
                && (rx_sh[44:39] != idx_q);
  assign end_bad = !cmd_in_i;

`ifdef SDCARD_CMD_CRC_CHECK_EN
  logic       rx_crc_en;
  logic       rx_crc_win;
  logic [6:0] rx_crc;

  assign rx_crc_win = is136 ? (cnt_q >= 8'd8 && cnt_q < 8'd128)
                            : (cnt_q < 8'(CRC_BITS));
  assign rx_crc_en  = strobe && (
      (state_q == ST_WAIT && start_bit && !is136) ||
      (state_q == ST_RX && rx_crc_win));

  sdcard_crc7 u_rx_crc (
    .clk    (PCLK_i),
    .rst_n  (PRESETn_i),
    .clear  (state_q == ST_IDLE),
    .enable (rx_crc_en),
    .bit_in (cmd_in_i),
    .crc    (rx_crc)
  );

  assign crc_bad = (rtype_q != RESP_R3)
                && (rx_crc != rx_sh[6:0]);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (cmd_start_i) state_d = ST_TX;
      ST_TX:
        if (strobe && cnt_q == 8'(FRAME48 - 1))
          state_d = (rtype_q == RESP_NONE) ? ST_TURN
                                           : ST_WAIT;
      ST_WAIT:
        if (strobe) begin
          if (start_bit)    state_d = ST_RX;
          else if (tmo_hit) state_d = ST_TURN;
        end
      ST_RX:
        if (strobe && last_rx) state_d = ST_TURN;
      ST_TURN:
        if (strobe && cnt_q == 8'(NCC_CYCLES - 1))
          state_d = ST_DONE;
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      rtype_q <= RESP_NONE;
      idx_q   <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      resp_q  <= '0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else if (abort) begin
      cnt_q <= '0;
      out_q <= 1'b1;
      oe_q  <= 1'b0;
    end else begin
      if (state_d != state_q)
        cnt_q <= (state_d == ST_RX) ? 8'd1 : 8'd0;
      else if (strobe)
        cnt_q <= cnt_q + 8'd1;

      if (strobe && state_q != ST_IDLE
          && state_q != ST_TX) begin
        out_q <= 1'b1;
        oe_q  <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE:
          if (cmd_start_i) begin
            idx_q   <= cmd_index_i;
            rtype_q <= resp_t'(resp_type_i);
            tx_sh   <= {2'b01, cmd_index_i, cmd_arg_i};
            err_q   <= '0;
            tmo_q   <= '0;
          end
        ST_TX:
          if (strobe) begin
            oe_q  <= 1'b1;
            out_q <= tx_bit;
            tx_sh <= {tx_sh[38:0], 1'b0};
          end
        ST_WAIT:
          if (strobe) begin
            rx_sh <= {rx_sh[126:0], cmd_in_i};
            if (!start_bit) begin
              if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
              if (tmo_hit) err_q[ERR_TMO] <= 1'b1;
            end
          end
        ST_RX:
          if (strobe) begin
            rx_sh <= {rx_sh[126:0], cmd_in_i};
            if (last_rx) begin
              err_q[ERR_END] <= end_bad;
              err_q[ERR_CRC] <= crc_bad;
              err_q[ERR_IDX] <= idx_bad;
            end
          end
        ST_DONE:
          if (rtype_q != RESP_NONE && !err_q[ERR_TMO])
            resp_q <= is136 ? rx_sh
                            : {90'b0, rx_sh[45:8]};
        default: ;
      endcase
    end
  end

  assign cmd_out_o   = out_q;
  assign cmd_oe_o    = oe_q;
  assign cmd_ready_o = state_q == ST_IDLE;
  assign cmd_busy_o  = state_q != ST_IDLE;
  assign done_o      = state_q == ST_DONE;
  assign resp_o      = resp_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sdcard_cmd_engine.sv
// Randomized bench for sdcard_cmd_engine with a frame-level card model.
// Honors SDCARD_CMD_CRC_CHECK_EN when deciding expected CRC errors.
module tb_sdcard_cmd_engine;

  localparam int TMO = 64;
  localparam int NCC = 8;

  logic         PCLK_i = 1'b0;
  logic         PRESETn_i;
  logic         sd_clk_en_i;
  logic         cmd_start_i;
  logic [5:0]   cmd_index_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   resp_type_i;
  logic         cmd_abort_i;
  logic         cmd_in_i;
  logic         cmd_out_o;
  logic         cmd_oe_o;
  logic         cmd_ready_o;
  logic         cmd_busy_o;
  logic         done_o;
  logic [127:0] resp_o;
  logic [3:0]   err_o;

  sdcard_cmd_engine #(
    .RESP_TIMEOUT (TMO),
    .NCC_CYCLES   (NCC)
  ) dut (
    .PCLK_i      (PCLK_i),
    .PRESETn_i   (PRESETn_i),
    .sd_clk_en_i (sd_clk_en_i),
    .cmd_start_i (cmd_start_i),
    .cmd_index_i (cmd_index_i),
    .cmd_arg_i   (cmd_arg_i),
    .resp_type_i (resp_type_i),
    .cmd_abort_i (cmd_abort_i),
    .cmd_in_i    (cmd_in_i),
    .cmd_out_o   (cmd_out_o),
    .cmd_oe_o    (cmd_oe_o),
    .cmd_ready_o (cmd_ready_o),
    .cmd_busy_o  (cmd_busy_o),
    .done_o      (done_o),
    .resp_o      (resp_o),
    .err_o       (err_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  int           errors = 0;
  int           checks = 0;
  int           strobes;
  int           done_cnt;
  int           done_at;
  logic         busy_at_done;
  logic [127:0] resp_m;

  task automatic check(input string tag,
                       input logic [135:0] got,
                       input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of m(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_ref(input logic [119:0] m);
    logic [126:0] v;
    v = {m, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (v[i]) v = v ^ (127'(8'h89) << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx,
                                            input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_ref(120'(h)), 1'b1};
  endfunction

  function automatic logic [47:0] r48_frame(input logic [5:0] idx,
                                            input logic [31:0] st);
    logic [39:0] h;
    h = {2'b00, idx, st};
    return {h, crc7_ref(120'(h)), 1'b1};
  endfunction

  function automatic logic [135:0] r136_frame(input logic [119:0] p);
    return {8'h3F, p, crc7_ref(p), 1'b1};
  endfunction

  function automatic logic [3:0] exp_err_f(input logic [1:0] rt,
                                           input bit reply,
                                           input logic [135:0] rf,
                                           input logic [5:0] idx);
    logic [3:0] e;
    e = '0;
    if (rt == 2'b00) return '0;
    if (!reply) return 4'b0001;
    e[2] = ~rf[0];
    if (rt == 2'b10) begin
      e[1] = crc7_ref(rf[127:8]) != rf[7:1];
    end else if (rt == 2'b01) begin
      e[3] = rf[45:40] != idx;
      e[1] = crc7_ref(120'(rf[47:8])) != rf[7:1];
    end
`ifndef SDCARD_CMD_CRC_CHECK_EN
    e[1] = 1'b0;
`endif
    return e;
  endfunction

  task automatic cyc(input logic en, input logic line);
    sd_clk_en_i = en;
    cmd_in_i    = line;
    @(posedge PCLK_i);
    @(negedge PCLK_i);
    sd_clk_en_i = 1'b0;
    cmd_start_i = 1'b0;
    cmd_abort_i = 1'b0;
    if (en) strobes++;
    if (done_o) begin
      done_cnt++;
      done_at      = strobes;
      busy_at_done = cmd_busy_o;
    end
  endtask

  // Idle cycles carry random line values that must not be sampled.
  task automatic strobe(input logic line);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) cyc(1'b0, 1'($urandom));
    cyc(1'b1, line);
  endtask

  task automatic run_cmd(input logic [5:0] idx,
                         input logic [31:0] arg,
                         input logic [1:0] rt,
                         input bit reply,
                         input logic [135:0] rf,
                         input int dly,
                         output logic [47:0] tx_obs);
    logic [47:0] exp_tx;
    logic [3:0]  e;
    logic        line;
    int          len;
    int          exp_lat;
    int          oe_bad;
    int          p;
    exp_tx = cmd_frame(idx, arg);
    len    = (rt == 2'b10) ? 136 : 48;
    if (rt == 2'b00)  exp_lat = 48 + NCC;
    else if (!reply)  exp_lat = 48 + TMO + NCC;
    else              exp_lat = 48 + dly + len + NCC;
    cmd_index_i = idx;
    cmd_arg_i   = arg;
    resp_type_i = rt;
    cmd_start_i = 1'b1;
    cyc(1'b0, 1'b1);
    check("start_busy", 136'({cmd_busy_o, cmd_ready_o}),
          136'(2'b10));
    strobes  = 0;
    done_cnt = 0;
    done_at  = 0;
    oe_bad   = 0;
    tx_obs   = '0;
    for (int k = 1; k <= 48; k++) begin
      if (k == 11) begin
        cmd_start_i = 1'b1;
        cmd_index_i = ~idx;
        cmd_arg_i   = ~arg;
        resp_type_i = ~rt;
      end
      strobe(1'b1);
      tx_obs = {tx_obs[46:0], cmd_out_o};
      if (!cmd_oe_o) oe_bad++;
    end
    check("tx_frame", 136'(tx_obs), 136'(exp_tx));
    check("tx_oe", 136'(oe_bad), 136'(0));
    while (done_cnt == 0 && strobes < 600) begin
      p    = strobes + 1 - 49 - dly;
      line = (reply && rt != 2'b00 && p >= 0 && p < len)
             ? rf[len-1-p] : 1'b1;
      strobe(line);
      if (strobes == 49)
        check("oe_release", 136'({cmd_oe_o, cmd_out_o}),
              136'(2'b01));
    end
    check("latency", 136'(done_at), 136'(exp_lat));
    check("busy_at_done", 136'(busy_at_done), 136'(1));
    cyc(1'b0, 1'b1);
    check("done_once", 136'(done_cnt), 136'(1));
    check("idle_after", 136'({cmd_ready_o, cmd_busy_o, done_o}),
          136'(3'b100));
    e = exp_err_f(rt, reply, rf, idx);
    if (rt != 2'b00 && reply)
      resp_m = (rt == 2'b10) ? rf[127:0] : {90'b0, rf[45:8]};
    check("err", 136'(err_o), 136'(e));
    check("resp", 136'(resp_o), 136'(resp_m));
  endtask

  initial begin
    logic [47:0]  txo;
    logic [135:0] rf;
    logic [1:0]   rt;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           mode;
    int           dly;

    PRESETn_i   = 1'b0;
    sd_clk_en_i = 1'b0;
    cmd_start_i = 1'b0;
    cmd_index_i = '0;
    cmd_arg_i   = '0;
    resp_type_i = '0;
    cmd_abort_i = 1'b0;
    cmd_in_i    = 1'b1;
    resp_m      = '0;
    repeat (3) @(negedge PCLK_i);
    check("rst_ctl", 136'({cmd_out_o, cmd_oe_o, cmd_ready_o,
                           cmd_busy_o, done_o}), 136'(5'b10100));
    check("rst_resp", 136'(resp_o), 136'(0));
    check("rst_err", 136'(err_o), 136'(0));
    PRESETn_i = 1'b1;
    cyc(1'b0, 1'b1);

    run_cmd(6'd0, 32'h0, 2'b00, 1'b0, '0, 1, txo);
    check("cmd0_line", 136'(txo), 136'(48'h40_0000_0000_95));

    rf = 136'(48'h08_0000_01AA_13);
    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, rf, 5, txo);
    check("cmd8_resp", 136'(resp_o),
          136'({90'b0, 6'd8, 32'h1AA}));
    check("cmd8_err", 136'(err_o), 136'(0));

    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, '0, 1, txo);
    check("cmd8_tmo", 136'(err_o), 136'(4'b0001));

    rf = 136'(48'h08_0000_01AA_15);
    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, rf, 3, txo);
`ifdef SDCARD_CMD_CRC_CHECK_EN
    check("cmd8_crc", 136'(err_o), 136'(4'b0010));
`else
    check("cmd8_crc", 136'(err_o), 136'(4'b0000));
`endif

    rf = 136'(48'h09_0000_01AA_13);
    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, rf, 7, txo);
    check("cmd8_idx", 136'(err_o[3]), 136'(1));

    rf = r136_frame({$urandom, $urandom, $urandom, 24'($urandom)});
    run_cmd(6'd2, 32'h0, 2'b10, 1'b1, rf, 4, txo);
    check("cmd2_resp", 136'(resp_o), 136'(rf[127:0]));
    check("cmd2_err", 136'(err_o), 136'(0));

    cmd_index_i = 6'd17;
    cmd_arg_i   = $urandom;
    resp_type_i = 2'b01;
    cmd_start_i = 1'b1;
    cyc(1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) cmd_start_i = 1'b1;
      strobe(1'b1);
    end
    cmd_abort_i = 1'b1;
    cyc(1'b1, 1'b1);
    check("abort_ctl", 136'({cmd_oe_o, cmd_out_o, cmd_ready_o,
                             cmd_busy_o}), 136'(4'b0110));
    check("abort_err", 136'(err_o), 136'(0));
    done_cnt = 0;
    for (int k = 0; k < 150; k++) strobe(1'($urandom));
    check("abort_no_done", 136'({done_cnt, cmd_ready_o}),
          136'({32'd0, 1'b1}));
    check("abort_resp", 136'(resp_o), 136'(resp_m));

    cmd_index_i = 6'd55;
    resp_type_i = 2'b01;
    cmd_start_i = 1'b1;
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) strobe(1'b1);
    PRESETn_i = 1'b0;
    #1;
    resp_m = '0;
    check("midrst_ctl", 136'({cmd_out_o, cmd_oe_o, cmd_ready_o,
                              cmd_busy_o, done_o}), 136'(5'b10100));
    check("midrst_resp", 136'(resp_o), 136'(0));
    @(negedge PCLK_i);
    PRESETn_i = 1'b1;
    cyc(1'b0, 1'b1);

    for (int t = 0; t < 14; t++) begin
      rt   = 2'($urandom);
      idx  = 6'($urandom);
      arg  = $urandom;
      dly  = $urandom_range(1, 20);
      mode = $urandom_range(0, 5);
      if (rt == 2'b10)
        rf = r136_frame({$urandom, $urandom, $urandom,
                         24'($urandom)});
      else
        rf = 136'(r48_frame(idx, $urandom));
      case (mode)
        3: rf[7:1] = rf[7:1] ^ 7'($urandom_range(1, 127));
        4: if (rt != 2'b10)
             rf[45:40] = rf[45:40] ^ 6'($urandom_range(1, 63));
        5: rf[0] = 1'b0;
        default: ;
      endcase
      run_cmd(idx, arg, rt, mode != 2, rf, dly, txo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
